rf_multiport_sb: RTL and testbench



---
 rtl/cpu_pkg.sv | 11 +
 rtl/rf_multiport_sb_if.sv | 27 ++
 rtl/rf_scoreboard.sv | 66 ++++++
 rtl/rf_multiport_sb.sv | 61 ++++++
 tb/tb_rf_multiport_sb.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and register typedefs used by the register file and its clients.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rf_multiport_sb_if.sv
// Register-file bus: writeback write port, decode read ports, issue/scoreboard status.
interface rf_multiport_sb_if #(
   parameter int DATA_W = cpu_pkg::REG_DATA_W,
   parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
   parameter int NREAD  = 2
);
   logic                    we;
   logic [ADDR_W-1:0]       wa;
   logic [DATA_W-1:0]       wd;
   logic [NREAD*ADDR_W-1:0] ra;
   logic [NREAD*DATA_W-1:0] rd;
   logic [NREAD-1:0]        rd_busy;
   logic                    iss_en;
   logic [ADDR_W-1:0]       iss_addr;
   logic [ADDR_W:0]         sb_cnt;
   logic                    wr_err;

   modport master (
      output we, wa, wd, ra, iss_en, iss_addr,
      input  rd, rd_busy, sb_cnt, wr_err
   );

   modport slave (
      input  we, wa, wd, ra, iss_en, iss_addr,
      output rd, rd_busy, sb_cnt, wr_err
   );
endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: issue sets a bit, writeback clears it; tracks count and stray writes.
module rf_scoreboard
   import cpu_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       wa,
   input  logic                    iss_en,
   input  logic [ADDR_W-1:0]       iss_addr,
   input  logic [NREAD*ADDR_W-1:0] ra,
   output logic [NREAD-1:0]        rd_busy,
   output logic [ADDR_W:0]         sb_cnt,
   output logic                    wr_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);

   logic [DEPTH-1:0] sb, sb_nxt;
   logic             clr, set, inc, dec;
   logic [ADDR_W:0]  cnt_nxt;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      clr    = we && (wa != ZERO);
      set    = iss_en && (iss_addr != ZERO);
      sb_nxt = sb;
      if (clr) sb_nxt[wa] = 1'b0;
      // Set is applied after clear so a newer producer keeps the register pending.
      if (set) sb_nxt[iss_addr] = 1'b1;
      inc     = set && !sb[iss_addr];
      dec     = clr && sb[wa] && !(set && (iss_addr == wa));
      cnt_nxt = sb_cnt;
      if (inc && !dec)      cnt_nxt = sb_cnt + ONE;
      else if (dec && !inc) cnt_nxt = sb_cnt - ONE;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sb     <= '0;
         sb_cnt <= '0;
         wr_err <= 1'b0;
      end else begin
         sb     <= sb_nxt;
         sb_cnt <= cnt_nxt;
         if (clr && !sb[wa]) wr_err <= 1'b1;
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NREAD; i++) begin
         rd_busy[i] = sb[ra[i*ADDR_W +: ADDR_W]]
                    & ~((BYPASS != 0) && we && (wa == ra[i*ADDR_W +: ADDR_W]))
                    & (ra[i*ADDR_W +: ADDR_W] != ZERO);
      end
   end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-read-port register file with write-to-read bypass and a pending-write scoreboard.
module rf_multiport_sb
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1
) (
   input logic               clk,
   input logic               rstn,
   rf_multiport_sb_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0]       mem [DEPTH];
   logic [NREAD*DATA_W-1:0] rd_vec;

   // NOTE: the array is reset because software relies on every register reading 0 after reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (bus.we && (bus.wa != ZERO)) begin
         mem[bus.wa] <= bus.wd;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      assign a = bus.ra[i*ADDR_W +: ADDR_W];
      always_comb begin
         if (a == ZERO)                                  d = '0;
         else if ((BYPASS != 0) && bus.we && bus.wa == a) d = bus.wd;
         else                                            d = mem[a];
      end
      assign rd_vec[i*DATA_W +: DATA_W] = d;
   end

   assign bus.rd = rd_vec;

   rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .NREAD  (NREAD),
      .BYPASS (BYPASS)
   ) u_sb (
      .clk      (clk),
      .rstn     (rstn),
      .we       (bus.we),
      .wa       (bus.wa),
      .iss_en   (bus.iss_en),
      .iss_addr (bus.iss_addr),
      .ra       (bus.ra),
      .rd_busy  (bus.rd_busy),
      .sb_cnt   (bus.sb_cnt),
      .wr_err   (bus.wr_err)
   );

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Scoreboard bench: a bypassing and a non-bypassing register file driven with the same directed vectors.
module tb_rf_multiport_sb;
   import cpu_pkg::*;

   typedef enum int {K_RD, K_BUSY, K_CNT, K_ERR} kind_t;
   typedef struct {
      string       name;
      int          dut;
      kind_t       kind;
      int          port;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   rf_multiport_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) if_a ();
   rf_multiport_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) if_b ();

   rf_multiport_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1)) dut_a (
      .clk (clk), .rstn (rstn), .bus (if_a));
   rf_multiport_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(0)) dut_b (
      .clk (clk), .rstn (rstn), .bus (if_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] actual(input exp_t e);
      logic [31:0] v;
      v = '0;
      case (e.kind)
         K_RD:   v = (e.dut == 0) ? if_a.rd[e.port*32 +: 32] : if_b.rd[e.port*32 +: 32];
         K_BUSY: v = 32'((e.dut == 0) ? if_a.rd_busy[e.port] : if_b.rd_busy[e.port]);
         K_CNT:  v = 32'((e.dut == 0) ? if_a.sb_cnt : if_b.sb_cnt);
         K_ERR:  v = 32'((e.dut == 0) ? if_a.wr_err : if_b.wr_err);
         default: v = 'x;
      endcase
      return v;
   endfunction

   // Monitor: every expectation queued during a cycle is compared at that cycle's falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%s]", e.name, e.dut == 0 ? "byp" : "nobyp"), actual(e), e.val);
         end
      end
   end

   // dut: 0 = bypassing, 1 = non-bypassing, 2 = both
   task automatic expect_v(input string name, input int dut, input kind_t kind,
                           input int port, input logic [31:0] val);
      exp_t e;
      e.name = name; e.kind = kind; e.port = port; e.val = val;
      if (dut != 1) begin e.dut = 0; exp_q.push_back(e); end
      if (dut != 0) begin e.dut = 1; exp_q.push_back(e); end
   endtask

   task automatic drive(input logic we, input reg_addr_t wa, input reg_data_t wd,
                        input reg_addr_t ra0, input reg_addr_t ra1,
                        input logic iss, input reg_addr_t ia);
      if_a.we = we; if_a.wa = wa; if_a.wd = wd; if_a.ra = {ra1, ra0};
      if_a.iss_en = iss; if_a.iss_addr = ia;
      if_b.we = we; if_b.wa = wa; if_b.wd = wd; if_b.ra = {ra1, ra0};
      if_b.iss_en = iss; if_b.iss_addr = ia;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
      step();
      step();
      rstn = 1'b1;

      // Reset state across the whole address range
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, '0, '0, reg_addr_t'(a), reg_addr_t'(31 - a), 1'b0, '0);
         expect_v($sformatf("rst_rd0_a%0d", a), 2, K_RD, 0, 32'h0);
         expect_v($sformatf("rst_rd1_a%0d", a), 2, K_RD, 1, 32'h0);
         expect_v($sformatf("rst_busy_a%0d", a), 0, K_BUSY, 0, 32'h0);
         if (a == 0) begin
            expect_v("rst_cnt", 2, K_CNT, 0, 32'd0);
            expect_v("rst_err", 2, K_ERR, 0, 32'd0);
         end
         step();
      end

      // Issue r5, then write it with a same-cycle read
      drive(1'b0, '0, '0, '0, '0, 1'b1, 5'd5);
      step();
      drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, '0, 1'b0, '0);
      expect_v("byp_rd0", 0, K_RD, 0, 32'hDEADBEEF);
      expect_v("byp_rd0", 1, K_RD, 0, 32'h0);
      expect_v("byp_busy0", 0, K_BUSY, 0, 32'h0);
      expect_v("byp_busy0", 1, K_BUSY, 0, 32'h1);
      step();
      drive(1'b0, '0, '0, '0, 5'd5, 1'b0, '0);
      expect_v("stored_rd1", 2, K_RD, 1, 32'hDEADBEEF);
      expect_v("w5_cnt", 2, K_CNT, 0, 32'd0);
      expect_v("w5_err", 2, K_ERR, 0, 32'd0);
      step();

      // r0 is hardwired: writes and issues to it are ignored
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
      expect_v("r0_byp_rd0", 2, K_RD, 0, 32'h0);
      step();
      drive(1'b0, '0, '0, 5'd0, '0, 1'b0, '0);
      expect_v("r0_rd0", 2, K_RD, 0, 32'h0);
      expect_v("r0_cnt", 2, K_CNT, 0, 32'd0);
      expect_v("r0_err", 2, K_ERR, 0, 32'd0);
      expect_v("r0_busy", 2, K_BUSY, 0, 32'h0);
      step();

      // Issue r7, stall on it, then write back
      drive(1'b0, '0, '0, '0, '0, 1'b1, 5'd7);
      step();
      drive(1'b0, '0, '0, 5'd7, '0, 1'b0, '0);
      expect_v("i7_cnt", 2, K_CNT, 0, 32'd1);
      expect_v("i7_busy0", 2, K_BUSY, 0, 32'h1);
      step();
      drive(1'b1, 5'd7, 32'h12, 5'd7, '0, 1'b0, '0);
      expect_v("w7_busy0", 0, K_BUSY, 0, 32'h0);
      expect_v("w7_busy0", 1, K_BUSY, 0, 32'h1);
      expect_v("w7_rd0", 0, K_RD, 0, 32'h12);
      expect_v("w7_rd0", 1, K_RD, 0, 32'h0);
      step();
      drive(1'b0, '0, '0, 5'd7, '0, 1'b0, '0);
      expect_v("w7_cnt", 2, K_CNT, 0, 32'd0);
      expect_v("w7_stored", 2, K_RD, 0, 32'h12);
      expect_v("w7_busy_after", 2, K_BUSY, 0, 32'h0);
      step();

      // Set and clear on the same register: set wins
      drive(1'b0, '0, '0, '0, '0, 1'b1, 5'd9);
      step();
      drive(1'b1, 5'd9, 32'h99, 5'd9, '0, 1'b1, 5'd9);
      expect_v("sc9_busy0", 0, K_BUSY, 0, 32'h0);
      expect_v("sc9_busy0", 1, K_BUSY, 0, 32'h1);
      step();
      drive(1'b0, '0, '0, 5'd9, '0, 1'b0, '0);
      expect_v("sc9_cnt", 2, K_CNT, 0, 32'd1);
      expect_v("sc9_busy", 2, K_BUSY, 0, 32'h1);
      expect_v("sc9_rd", 2, K_RD, 0, 32'h99);
      step();

      // Set r3 while clearing r9: count unchanged
      drive(1'b1, 5'd9, 32'h77, '0, '0, 1'b1, 5'd3);
      step();
      drive(1'b0, '0, '0, 5'd3, 5'd9, 1'b0, '0);
      expect_v("s3c9_cnt", 2, K_CNT, 0, 32'd1);
      expect_v("s3c9_busy3", 2, K_BUSY, 0, 32'h1);
      expect_v("s3c9_busy9", 2, K_BUSY, 1, 32'h0);
      expect_v("s3c9_err", 2, K_ERR, 0, 32'd0);
      step();
      drive(1'b1, 5'd3, 32'h33, '0, '0, 1'b0, '0);
      step();
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
      expect_v("c3_cnt", 2, K_CNT, 0, 32'd0);
      step();

      // Write to a non-pending register: sticky error, write still lands
      drive(1'b1, 5'd12, 32'hAB, '0, '0, 1'b0, '0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, '0, '0, 5'd12, '0, 1'b0, '0);
         expect_v($sformatf("err_sticky%0d", i), 2, K_ERR, 0, 32'd1);
         expect_v($sformatf("err_rd12_%0d", i), 2, K_RD, 0, 32'hAB);
         step();
      end

      // Leave r4 pending, then reset with a concurrent write to r12
      drive(1'b0, '0, '0, '0, '0, 1'b1, 5'd4);
      step();
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
      expect_v("i4_cnt", 2, K_CNT, 0, 32'd1);
      step();
      rstn = 1'b0;
      drive(1'b1, 5'd12, 32'h55, '0, '0, 1'b0, '0);
      step();
      rstn = 1'b1;
      drive(1'b0, '0, '0, 5'd12, 5'd4, 1'b0, '0);
      expect_v("rst2_rd12", 2, K_RD, 0, 32'h0);
      expect_v("rst2_err", 2, K_ERR, 0, 32'd0);
      expect_v("rst2_cnt", 2, K_CNT, 0, 32'd0);
      expect_v("rst2_busy4", 2, K_BUSY, 1, 32'h0);
      step();

      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
